// File: rtl/disp_timing_gen_pkg.sv
// Shared types and helpers for the display timing generator: pattern codes,
// the pipelined control bundle and the colour-bar lookup.
package disp_timing_gen_pkg;

    typedef enum logic [1:0] {
        PAT_EXT    = 2'd0,
        PAT_BARS   = 2'd1,
        PAT_SOLID  = 2'd2,
        PAT_BORDER = 2'd3
    } pat_sel_e;

    localparam int unsigned NUM_BARS = 8;

    typedef struct packed {
        logic req;
        logic hs;
        logic vs;
        logic fb;
        logic lb;
    } ctrl_t;

    // Bar colour as per-channel on/off {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/disp_timing_gen_if.sv
// Pixel-source and display-side signals of the timing generator.
interface disp_timing_gen_if #(
    parameter int unsigned R_W    = 8,
    parameter int unsigned G_W    = 8,
    parameter int unsigned B_W    = 8,
    parameter int unsigned ADDR_W = 12
);
    localparam int unsigned PIX_W = R_W + G_W + B_W;

    logic [1:0]        Pattern_Sel;
    logic [PIX_W-1:0]  Solid_Color;
    logic [PIX_W-1:0]  Data_In;
    logic              DataReq;
    logic [ADDR_W-1:0] H_Addr;
    logic [ADDR_W-1:0] V_Addr;
    logic              Disp_Hs;
    logic              Disp_Vs;
    logic              Disp_De;
    logic [R_W-1:0]    Disp_Red;
    logic [G_W-1:0]    Disp_Green;
    logic [B_W-1:0]    Disp_Blue;
    logic              Frame_Begin;
    logic              Line_Begin;

    modport master (
        input  Pattern_Sel, Solid_Color, Data_In,
        output DataReq, H_Addr, V_Addr, Disp_Hs, Disp_Vs, Disp_De,
               Disp_Red, Disp_Green, Disp_Blue, Frame_Begin, Line_Begin
    );

    modport slave (
        output Pattern_Sel, Solid_Color, Data_In,
        input  DataReq, H_Addr, V_Addr, Disp_Hs, Disp_Vs, Disp_De,
               Disp_Red, Disp_Green, Disp_Blue, Frame_Begin, Line_Begin
    );

endinterface

// File: rtl/disp_timing_gen_delay_line.sv
// WIDTH x DEPTH shift register with synchronous clear; DEPTH=0 degenerates to a wire.
module disp_timing_gen_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/disp_timing_gen.sv
// Display timing generator: counters, request stage, pattern generation and
// a latency-matched output register so sync, DE and RGB leave aligned.
module disp_timing_gen
    import disp_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter int unsigned HS_POL   = 1,
    parameter int unsigned VS_POL   = 1,
    parameter int unsigned RD_LAT   = 0,
    parameter int unsigned R_W      = 8,
    parameter int unsigned G_W      = 8,
    parameter int unsigned B_W      = 8,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              clk_disp,
    input  logic              rst_p,
    disp_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned V_END   = V_START + V_ACTIVE;
    localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;
    localparam int unsigned PIX_W   = R_W + G_W + B_W;

    logic [ADDR_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    pat_sel_e          mode_q, mode_d, s1_mode_q;
    logic              s1_req_q, s1_req_d;
    logic [ADDR_W-1:0] s1_haddr_q, s1_haddr_d, s1_vaddr_q, s1_vaddr_d;
    logic              s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_fb_q, s1_fb_d, s1_lb_q, s1_lb_d;
    logic [ADDR_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic              out_de_q, out_de_d, out_hs_q, out_hs_d, out_vs_q, out_vs_d;
    logic              out_fb_q, out_fb_d, out_lb_q, out_lb_d;
    logic [PIX_W-1:0]  out_rgb_q, out_rgb_d;

    logic              line_end, frame_end, h_act, v_act, border, pat_ext;
    logic [2:0]        bar;
    logic [PIX_W-1:0]  pat_pix;
    ctrl_t             ctrl_s1, ctrl_dl;
    logic [PIX_W:0]    pix_s1, pix_dl;

    // Raster counters, mode capture and request-stage decode
    always_comb begin
        line_end  = (hcnt_q == ADDR_W'(H_TOTAL - 1));
        frame_end = line_end && (vcnt_q == ADDR_W'(V_TOTAL - 1));
        hcnt_d    = line_end ? '0 : hcnt_q + ADDR_W'(1);
        vcnt_d    = vcnt_q;
        if (line_end) begin
            vcnt_d = (vcnt_q == ADDR_W'(V_TOTAL - 1)) ? '0 : vcnt_q + ADDR_W'(1);
        end
        mode_d = frame_end ? pat_sel_e'(bus.Pattern_Sel) : mode_q;

        h_act      = (hcnt_q >= ADDR_W'(H_START)) && (hcnt_q < ADDR_W'(H_END));
        v_act      = (vcnt_q >= ADDR_W'(V_START)) && (vcnt_q < ADDR_W'(V_END));
        s1_req_d   = h_act && v_act;
        s1_haddr_d = s1_req_d ? hcnt_q - ADDR_W'(H_START) : '0;
        s1_vaddr_d = s1_req_d ? vcnt_q - ADDR_W'(V_START) : '0;
        s1_hs_d    = (hcnt_q < ADDR_W'(H_SYNC));
        s1_vs_d    = (vcnt_q < ADDR_W'(V_SYNC));
        s1_fb_d    = (hcnt_q == '0) && (vcnt_q == '0);
        s1_lb_d    = (hcnt_q == '0);

        // Bar index tracks the column by counting BAR_W pixels; the last bar takes the remainder
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (h_act && (hcnt_q != ADDR_W'(H_START))) begin
            if ((bar_cnt_q == ADDR_W'(BAR_W - 1)) && (bar_idx_q != 3'(NUM_BARS - 1))) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + ADDR_W'(1);
                bar_idx_d = bar_idx_q;
            end
        end
    end

    // Pattern pixel for the pixel held in the request stage
    always_comb begin
        border  = (s1_haddr_q == '0) || (s1_haddr_q == ADDR_W'(H_ACTIVE - 1)) ||
                  (s1_vaddr_q == '0) || (s1_vaddr_q == ADDR_W'(V_ACTIVE - 1));
        bar     = bar_rgb(bar_idx_q);
        pat_ext = 1'b0;
        pat_pix = '0;
        case (s1_mode_q)
            PAT_EXT:    pat_ext = 1'b1;
            PAT_BARS:   pat_pix = {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
            PAT_SOLID:  pat_pix = bus.Solid_Color;
            PAT_BORDER: begin
                if (border) pat_pix = '1;
                else        pat_ext = 1'b1;
            end
            default:    pat_ext = 1'b1;
        endcase
        ctrl_s1 = '{req: s1_req_q, hs: s1_hs_q, vs: s1_vs_q, fb: s1_fb_q, lb: s1_lb_q};
        pix_s1  = {pat_ext, pat_pix};
    end

    disp_timing_gen_delay_line #(.WIDTH($bits(ctrl_t)), .DEPTH(RD_LAT)) u_ctrl_dl (
        .clk  (clk_disp),
        .rst  (rst_p),
        .din  (ctrl_s1),
        .dout (ctrl_dl)
    );

    disp_timing_gen_delay_line #(.WIDTH(PIX_W + 1), .DEPTH(RD_LAT)) u_pix_dl (
        .clk  (clk_disp),
        .rst  (rst_p),
        .din  (pix_s1),
        .dout (pix_dl)
    );

    // Output stage: merge delayed pattern with source data arriving RD_LAT cycles after the request
    always_comb begin
        out_de_d  = ctrl_dl.req;
        out_hs_d  = ctrl_dl.hs ~^ 1'(HS_POL);
        out_vs_d  = ctrl_dl.vs ~^ 1'(VS_POL);
        out_fb_d  = ctrl_dl.fb;
        out_lb_d  = ctrl_dl.lb;
        out_rgb_d = '0;
        if (ctrl_dl.req) begin
            out_rgb_d = pix_dl[PIX_W] ? bus.Data_In : pix_dl[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk_disp) begin
        if (rst_p) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            mode_q     <= pat_sel_e'(bus.Pattern_Sel);
            s1_mode_q  <= PAT_EXT;
            s1_req_q   <= 1'b0;
            s1_haddr_q <= '0;
            s1_vaddr_q <= '0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_fb_q    <= 1'b0;
            s1_lb_q    <= 1'b0;
            bar_cnt_q  <= '0;
            bar_idx_q  <= '0;
            out_de_q   <= 1'b0;
            out_hs_q   <= ~1'(HS_POL);
            out_vs_q   <= ~1'(VS_POL);
            out_fb_q   <= 1'b0;
            out_lb_q   <= 1'b0;
            out_rgb_q  <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            mode_q     <= mode_d;
            s1_mode_q  <= mode_q;
            s1_req_q   <= s1_req_d;
            s1_haddr_q <= s1_haddr_d;
            s1_vaddr_q <= s1_vaddr_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_fb_q    <= s1_fb_d;
            s1_lb_q    <= s1_lb_d;
            bar_cnt_q  <= bar_cnt_d;
            bar_idx_q  <= bar_idx_d;
            out_de_q   <= out_de_d;
            out_hs_q   <= out_hs_d;
            out_vs_q   <= out_vs_d;
            out_fb_q   <= out_fb_d;
            out_lb_q   <= out_lb_d;
            out_rgb_q  <= out_rgb_d;
        end
    end

    assign bus.DataReq     = s1_req_q;
    assign bus.H_Addr      = s1_haddr_q;
    assign bus.V_Addr      = s1_vaddr_q;
    assign bus.Disp_De     = out_de_q;
    assign bus.Disp_Hs     = out_hs_q;
    assign bus.Disp_Vs     = out_vs_q;
    assign bus.Frame_Begin = out_fb_q;
    assign bus.Line_Begin  = out_lb_q;
    assign bus.Disp_Red    = out_rgb_q[PIX_W-1 -: R_W];
    assign bus.Disp_Green  = out_rgb_q[G_W+B_W-1 -: G_W];
    assign bus.Disp_Blue   = out_rgb_q[B_W-1:0];

endmodule

// File: tb/tb_disp_timing_gen.sv
// Randomized bench for disp_timing_gen against a position-based raster model.
`timescale 1ns/1ps
module tb_disp_timing_gen;

    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACTIVE = 4,  V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int HS_POL = 0, VS_POL = 0, RD_LAT = 2, ADDR_W = 12;
    localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int FT = HT * VT;
    localparam int HST = H_SYNC + H_BP;
    localparam int VST = V_SYNC + V_BP;
    localparam int BAR_W = H_ACTIVE / 8;

    logic clk_disp = 1'b0;
    logic rst_p;
    always #5 clk_disp = ~clk_disp;

    disp_timing_gen_if #(.R_W(8), .G_W(8), .B_W(8), .ADDR_W(ADDR_W)) bus ();

    disp_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .RD_LAT(RD_LAT),
        .R_W(8), .G_W(8), .B_W(8), .ADDR_W(ADDR_W)
    ) dut (
        .clk_disp (clk_disp),
        .rst_p    (rst_p),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;
    int n = 0;            // clock edges since the last reset edge
    bit started = 1'b0;
    int src_kind = 0;     // 0: address-coded source, 1: all-zero source
    int frame_mode [int];
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct { bit req; int h; int v; } req_t;
    req_t rq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d after reset)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [23:0] src_pix(input int x, input int y);
        logic [23:0] p;
        p = (src_kind == 0) ? {8'(x), 8'(y), 8'h5A} : 24'h000000;
        return p;
    endfunction

    function automatic logic [23:0] ref_pix(input int mode, input int x, input int y);
        int b;
        case (mode)
            0: return src_pix(x, y);
            1: begin
                b = x / BAR_W;
                if (b > 7) b = 7;
                return bar_tab[b];
            end
            2: return bus.Solid_Color;
            default: begin
                if (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1) return 24'hFFFFFF;
                return src_pix(x, y);
            end
        endcase
    endfunction

    task automatic check_cycle();
        int p, h, v, f;
        bit act;
        logic [23:0] exp_rgb;
        // request stage shows raster position n-1
        if (n == 0) begin
            chk("DataReq", 32'(bus.DataReq), 32'd0);
            chk("H_Addr", 32'(bus.H_Addr), 32'd0);
            chk("V_Addr", 32'(bus.V_Addr), 32'd0);
        end else begin
            p = n - 1; h = p % HT; v = (p / HT) % VT;
            act = (h >= HST && h < HST + H_ACTIVE && v >= VST && v < VST + V_ACTIVE);
            chk("DataReq", 32'(bus.DataReq), 32'(act));
            chk("H_Addr", 32'(bus.H_Addr), act ? 32'(h - HST) : 32'd0);
            chk("V_Addr", 32'(bus.V_Addr), act ? 32'(v - VST) : 32'd0);
        end
        // display outputs show position n-RD_LAT-2
        if (n < RD_LAT + 2) begin
            chk("Disp_De", 32'(bus.Disp_De), 32'd0);
            chk("Disp_Hs", 32'(bus.Disp_Hs), (HS_POL != 0) ? 32'd0 : 32'd1);
            chk("Disp_Vs", 32'(bus.Disp_Vs), (VS_POL != 0) ? 32'd0 : 32'd1);
            chk("RGB", 32'({bus.Disp_Red, bus.Disp_Green, bus.Disp_Blue}), 32'd0);
            chk("Frame_Begin", 32'(bus.Frame_Begin), 32'd0);
            chk("Line_Begin", 32'(bus.Line_Begin), 32'd0);
        end else begin
            p = n - RD_LAT - 2; h = p % HT; v = (p / HT) % VT; f = p / FT;
            act = (h >= HST && h < HST + H_ACTIVE && v >= VST && v < VST + V_ACTIVE);
            exp_rgb = act ? ref_pix(frame_mode[f], h - HST, v - VST) : 24'h000000;
            chk("Disp_De", 32'(bus.Disp_De), 32'(act));
            chk("Disp_Hs", 32'(bus.Disp_Hs), 32'((h < H_SYNC) == (HS_POL != 0)));
            chk("Disp_Vs", 32'(bus.Disp_Vs), 32'((v < V_SYNC) == (VS_POL != 0)));
            chk("RGB", 32'({bus.Disp_Red, bus.Disp_Green, bus.Disp_Blue}), 32'(exp_rgb));
            chk("Frame_Begin", 32'(bus.Frame_Begin), 32'(p % FT == 0));
            chk("Line_Begin", 32'(bus.Line_Begin), 32'(h == 0));
        end
    endtask

    // Model update on each edge, output check just after it, then the pixel source
    always @(posedge clk_disp) begin
        req_t s;
        if (rst_p) begin
            frame_mode.delete();
            frame_mode[0] = int'(bus.Pattern_Sel);
            n = 0;
        end else begin
            if (n % FT == FT - 1) frame_mode[n / FT + 1] = int'(bus.Pattern_Sel);
            n++;
        end
        started = 1'b1;
        #1;
        check_cycle();
        s.req = bus.DataReq; s.h = int'(bus.H_Addr); s.v = int'(bus.V_Addr);
        rq.push_back(s);
        if (rq.size() > RD_LAT) begin
            s = rq.pop_front();
            bus.Data_In = s.req ? src_pix(s.h, s.v) : 24'($urandom);
        end else begin
            bus.Data_In = 24'($urandom);
        end
    end

    task automatic wait_pos(input int target);
        int k = 0;
        while (n != target && k < 4 * FT) begin
            @(negedge clk_disp);
            k++;
        end
        if (n != target) chk("wait_pos", 32'(n), 32'(target));
    endtask

    initial begin
        rst_p = 1'b1;
        bus.Pattern_Sel = 2'd0;
        bus.Solid_Color = 24'h123456;
        repeat (5) @(negedge clk_disp);
        rst_p = 1'b0;
        // mid-frame switch to bars: frame 2 stays external, frame 3 shows bars
        wait_pos(2 * FT + 40 + int'($urandom_range(0, 100)));
        bus.Pattern_Sel = 2'd1;
        wait_pos(3 * FT + 100);
        src_kind = 1;
        bus.Pattern_Sel = 2'd3;
        wait_pos(4 * FT + 60);
        bus.Pattern_Sel = 2'd2;
        // one-cycle reset with the counter at hcnt=10, vcnt=2
        wait_pos(5 * FT + 2 * HT + 10);
        rst_p = 1'b1;
        bus.Pattern_Sel = 2'd0;
        src_kind = 0;
        @(negedge clk_disp);
        rst_p = 1'b0;
        wait_pos(2 * FT + 10);
        for (int f = 0; f < 4; f++) begin
            wait_pos((2 + f) * FT + int'($urandom_range(20, FT - 2)));
            bus.Pattern_Sel = 2'($urandom_range(0, 3));
        end
        // reset at a random point with new solid colour and mode
        wait_pos(6 * FT + int'($urandom_range(1, FT - 2)));
        rst_p = 1'b1;
        bus.Solid_Color = 24'($urandom);
        bus.Pattern_Sel = 2'($urandom_range(0, 3));
        repeat ($urandom_range(1, 3)) @(negedge clk_disp);
        rst_p = 1'b0;
        wait_pos(FT + FT / 2);
        repeat (2) @(negedge clk_disp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
